fifo_uart_tx: RTL

//  Reader side of the TX byte FIFO (syn_fifo) in the AXI4-Lite-to-UART bridge.
//  - Pops one byte at a time from the FIFO and serializes it as an 8N1 UART frame
//    (or 8N2 when STOP_BITS = 2), LSB first, on tx_serial.
//  - Handles the FIFO's one-cycle registered read latency.
//  - Reports frame activity and completion to the bridge status logic.

---
 rtl/fifo_uart_tx_if.sv | 20 ++
 rtl/fifo_uart_tx.sv | 76 +++++++
 2 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read handshake plus UART line/status signals between the TX serializer and its surroundings.
interface fifo_uart_tx_if;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  modport master (
    input  enable, fifo_empty, fifo_rd_data,
    output fifo_rd_en, tx_serial, tx_active, tx_done
  );

  modport slave (
    output enable, fifo_empty, fifo_rd_data,
    input  fifo_rd_en, tx_serial, tx_active, tx_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the TX FIFO one at a time and serializes each as an 8N1/8N2 UART frame.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int STOP_BITS    = 1
) (
  input logic            clk,
  input logic            rst,
  fifo_uart_tx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, POP, WAIT, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_nxt;
  logic          stop_idx;
  logic [7:0]    shift_reg;
  logic          bit_end;
  logic          last_stop;

  assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign bit_nxt   = bit_idx + 3'd1;
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable && !bus.fifo_empty) state_nxt = POP;
      POP:     state_nxt = WAIT;
      WAIT:    state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_end && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_idx        <= '0;
      stop_idx       <= 1'b0;
      shift_reg      <= '0;
      bus.tx_serial  <= 1'b1;
      bus.fifo_rd_en <= 1'b0;
      bus.tx_active  <= 1'b0;
      bus.tx_done    <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.fifo_rd_en <= (state_nxt == POP);
      bus.tx_active  <= (state_nxt != IDLE);
      bus.tx_done    <= (state == STOP) && (state_nxt == IDLE);
      if ((state inside {START, DATA, STOP}) && !bit_end) baud_cnt <= baud_cnt + 1'b1;
      else                                                baud_cnt <= '0;
      case (state)
        WAIT: begin
          shift_reg     <= bus.fifo_rd_data;
          bus.tx_serial <= 1'b0;
          bit_idx       <= '0;
          stop_idx      <= 1'b0;
        end
        START: if (bit_end) bus.tx_serial <= shift_reg[0];
        DATA: if (bit_end) begin
          bus.tx_serial <= (bit_idx == 3'd7) ? 1'b1 : shift_reg[bit_nxt];
          bit_idx       <= bit_nxt;
        end
        STOP: if (bit_end) stop_idx <= ~stop_idx;
        default: bus.tx_serial <= 1'b1;
      endcase
    end
  end
endmodule
